// File: rtl/fir_coef_loader.sv
// Host-side sequencer that streams 16-bit coefficients (MSB byte then LSB byte)
// into one FIR coefficient RAM, holding the filter bank off while it rewrites.
module fir_coef_loader #(
    parameter int         taps_per_filter = 4,
    parameter int         WR_SPACING      = 4,
    parameter logic [8:0] COEFS_RESET     = 9'd255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [7:0]                 band,
    input  logic [8:0]                 coef_count,
    input  logic                       abort,
    input  logic [7:0]                 in_byte,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       coef_addr_rst,
    output logic                       coefficient_wr_en,
    output logic [taps_per_filter-1:0] coef_select,
    output logic [7:0]                 coef_wr_msb_data,
    output logic [7:0]                 coef_wr_lsb_data,
    output logic [7:0]                 coefs_per_tap_lsb,
    output logic                       coefs_per_tap_msb,
    output logic                       fir_hold,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    localparam int SEL_W = taps_per_filter;
    localparam int SPW   = $clog2(WR_SPACING + 1);

    typedef enum logic [2:0] {
        IDLE, ADDR_RST, GET_MSB, GET_LSB, WRITE, SPACE, FINISH
    } state_t;

    typedef struct packed {
        logic [7:0] band;
        logic [8:0] count;
    } load_req_t;

    state_t     state_q;
    load_req_t  req_q;
    logic [8:0] written_q, written_d;
    logic [SPW-1:0] space_q;
    logic [SEL_W-1:0] sel_q;
    logic [7:0] msb_q, lsb_q;
    logic [8:0] coefs_q;
    logic       addr_rst_q, wr_en_q, fir_hold_q, busy_q, done_q, error_q;

    logic start_ok, space_last;

    assign start_ok   = (coef_count != 9'd0) && (int'(band) < taps_per_filter);
    assign space_last = (space_q == SPW'(WR_SPACING - 1));
    assign written_d  = written_q + 9'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= '0;
            written_q  <= '0;
            space_q    <= '0;
            sel_q      <= '0;
            msb_q      <= '0;
            lsb_q      <= '0;
            coefs_q    <= COEFS_RESET;
            addr_rst_q <= 1'b0;
            wr_en_q    <= 1'b0;
            fir_hold_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            addr_rst_q <= 1'b0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            // Abort outranks byte acceptance and every state transition.
            if (abort && state_q != IDLE) begin
                state_q    <= IDLE;
                error_q    <= 1'b1;
                fir_hold_q <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            if (start_ok) begin
                                req_q      <= '{band: band, count: coef_count};
                                written_q  <= '0;
                                sel_q      <= SEL_W'(band);
                                addr_rst_q <= 1'b1;
                                fir_hold_q <= 1'b1;
                                busy_q     <= 1'b1;
                                state_q    <= ADDR_RST;
                            end else begin
                                error_q <= 1'b1;
                            end
                        end
                    end
                    ADDR_RST: state_q <= GET_MSB;
                    GET_MSB: begin
                        if (in_valid) begin
                            msb_q   <= in_byte;
                            state_q <= GET_LSB;
                        end
                    end
                    GET_LSB: begin
                        if (in_valid) begin
                            lsb_q   <= in_byte;
                            wr_en_q <= 1'b1;
                            state_q <= WRITE;
                        end
                    end
                    WRITE: begin
                        written_q <= written_d;
                        space_q   <= '0;
                        state_q   <= SPACE;
                    end
                    // The filter bumps its write address a few clocks after the
                    // strobe, so the next strobe must not arrive before then.
                    SPACE: begin
                        if (space_last) begin
                            if (written_q == req_q.count) begin
                                coefs_q <= req_q.count;
                                done_q  <= 1'b1;
                                state_q <= FINISH;
                            end else begin
                                state_q <= GET_MSB;
                            end
                        end else begin
                            space_q <= space_q + SPW'(1);
                        end
                    end
                    FINISH: begin
                        fir_hold_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign in_ready          = (state_q == GET_MSB) || (state_q == GET_LSB);
    assign coef_addr_rst     = addr_rst_q;
    assign coefficient_wr_en = wr_en_q;
    assign coef_select       = sel_q;
    assign coef_wr_msb_data  = msb_q;
    assign coef_wr_lsb_data  = lsb_q;
    assign coefs_per_tap_lsb = coefs_q[7:0];
    assign coefs_per_tap_msb = coefs_q[8];
    assign fir_hold          = fir_hold_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader: nominal loads, invalid starts, abort,
// asynchronous reset mid-load and the 511-coefficient boundary.
module tb_fir_coef_loader;

    logic       clk = 1'b0;
    logic       reset, start, abort, in_valid;
    logic [7:0] band, in_byte;
    logic [8:0] coef_count;
    logic       in_ready, coef_addr_rst, coefficient_wr_en;
    logic [3:0] coef_select;
    logic [7:0] coef_wr_msb_data, coef_wr_lsb_data, coefs_per_tap_lsb;
    logic       coefs_per_tap_msb, fir_hold, busy, done, error;

    fir_coef_loader dut (
        .clk(clk), .reset(reset), .start(start), .band(band), .coef_count(coef_count),
        .abort(abort), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .coef_addr_rst(coef_addr_rst), .coefficient_wr_en(coefficient_wr_en),
        .coef_select(coef_select), .coef_wr_msb_data(coef_wr_msb_data),
        .coef_wr_lsb_data(coef_wr_lsb_data), .coefs_per_tap_lsb(coefs_per_tap_lsb),
        .coefs_per_tap_msb(coefs_per_tap_msb), .fir_hold(fir_hold), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Strobe / pulse recorder, sampled mid-cycle.
    int         cyc = 0, n_addr = 0, n_done = 0, n_err = 0;
    logic [7:0] s_msb[$], s_lsb[$];
    logic [3:0] s_sel[$];
    int         s_cyc[$];
    logic [7:0] tx[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (coefficient_wr_en === 1'b1) begin
            s_msb.push_back(coef_wr_msb_data);
            s_lsb.push_back(coef_wr_lsb_data);
            s_sel.push_back(coef_select);
            s_cyc.push_back(cyc);
        end
        if (coef_addr_rst === 1'b1) n_addr <= n_addr + 1;
        if (done === 1'b1)          n_done <= n_done + 1;
        if (error === 1'b1)         n_err  <= n_err + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_start(input logic [7:0] b, input logic [8:0] n);
        @(negedge clk);
        start = 1'b1; band = b; coef_count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer tx[0..n-1]; a byte moves on the edge after a negedge where valid && ready.
    task automatic feed(input int n, input bit toggle);
        int i = 0;
        int k = 0;
        while (i < n && k < 20000) begin
            @(negedge clk);
            k++;
            in_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            in_byte  = tx[i];
            if (in_valid && in_ready) i++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("feed_bytes_taken", i, n);
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (done !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic load3(input bit toggle);
        int base, na, nd;
        logic [7:0] em[3];
        logic [7:0] el[3];
        em = '{8'h12, 8'h56, 8'h9A};
        el = '{8'h34, 8'h78, 8'hBC};
        base = s_msb.size(); na = n_addr; nd = n_done;
        do_start(8'd2, 9'd3);
        chk("addr_rst_after_start", coef_addr_rst, 1);
        chk("busy_in_addr_rst", busy, 1);
        chk("hold_in_addr_rst", fir_hold, 1);
        chk("select_in_addr_rst", coef_select, 2);
        chk("ready_in_addr_rst", in_ready, 0);
        tx = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        feed(6, toggle);
        wait_done(60);
        chk("coefs_lsb_3", coefs_per_tap_lsb, 3);
        chk("coefs_msb_3", coefs_per_tap_msb, 0);
        chk("hold_during_finish", fir_hold, 1);
        @(negedge clk);
        chk("hold_dropped", fir_hold, 0);
        chk("busy_dropped", busy, 0);
        chk("addr_rst_count", n_addr - na, 1);
        chk("done_count", n_done - nd, 1);
        chk("strobe_count", s_msb.size() - base, 3);
        for (int j = 0; j < 3; j++) begin
            if (s_msb.size() > base + j) begin
                chk("strobe_msb", s_msb[base+j], em[j]);
                chk("strobe_lsb", s_lsb[base+j], el[j]);
                chk("strobe_sel", s_sel[base+j], 2);
            end
            if (j > 0 && s_cyc.size() > base + j) begin
                if (toggle) chk("spacing_min7", (s_cyc[base+j] - s_cyc[base+j-1]) >= 7, 1);
                else        chk("spacing_eq7", s_cyc[base+j] - s_cyc[base+j-1], 7);
            end
        end
    endtask

    initial begin
        int base, nd, ne;
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        band = '0; in_byte = '0; coef_count = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        base = s_msb.size();
        repeat (10) @(negedge clk);
        chk("rst_coefs_lsb", coefs_per_tap_lsb, 8'hFF);
        chk("rst_coefs_msb", coefs_per_tap_msb, 0);
        chk("rst_fir_hold", fir_hold, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_select", coef_select, 0);
        chk("rst_no_strobes", s_msb.size() - base, 0);
        chk("rst_no_addr_rst", n_addr, 0);

        // Nominal loads
        load3(1'b0);
        load3(1'b1);

        // Rejected starts
        base = n_addr;
        do_start(8'd1, 9'd0);
        chk("cnt0_error", error, 1);
        chk("cnt0_busy", busy, 0);
        chk("cnt0_addr_rst", coef_addr_rst, 0);
        chk("cnt0_select_kept", coef_select, 2);
        do_start(8'd4, 9'd2);
        chk("band4_error", error, 1);
        chk("band4_busy", busy, 0);
        chk("band4_hold", fir_hold, 0);
        @(negedge clk);
        chk("bad_start_no_addr_rst", n_addr - base, 0);
        chk("bad_start_coefs_kept", coefs_per_tap_lsb, 3);

        // Abort after 2 of 5 coefficients
        base = s_msb.size(); nd = n_done;
        do_start(8'd1, 9'd5);
        tx = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        feed(4, 1'b0);
        for (int k = 0; k < 50 && s_msb.size() < base + 2; k++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_error", error, 1);
        chk("abort_hold", fir_hold, 0);
        chk("abort_ready", in_ready, 0);
        in_valid = 1'b1; in_byte = 8'hEE;
        repeat (30) @(negedge clk);
        in_valid = 1'b0;
        chk("abort_strobes", s_msb.size() - base, 2);
        chk("abort_coefs_kept", coefs_per_tap_lsb, 3);
        chk("abort_no_done", n_done - nd, 0);

        // Asynchronous reset while waiting for the LSB
        do_start(8'd3, 9'd1);
        tx = {8'h5A, 8'hA5};
        feed(1, 1'b0);
        chk("lsb_wait_ready", in_ready, 1);
        chk("lsb_wait_msb", coef_wr_msb_data, 8'h5A);
        nd = n_done; ne = n_err;
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_hold", fir_hold, 0);
        chk("arst_ready", in_ready, 0);
        chk("arst_select", coef_select, 0);
        chk("arst_msb", coef_wr_msb_data, 0);
        chk("arst_coefs_lsb", coefs_per_tap_lsb, 8'hFF);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("arst_no_pulses", (n_done - nd) + (n_err - ne), 0);
        base = s_msb.size();
        do_start(8'd3, 9'd1);
        tx = {8'hAB, 8'hCD};
        feed(2, 1'b0);
        wait_done(30);
        chk("post_rst_coefs", {coefs_per_tap_msb, coefs_per_tap_lsb}, 1);
        chk("post_rst_strobes", s_msb.size() - base, 1);
        if (s_msb.size() > base) begin
            chk("post_rst_msb", s_msb[base], 8'hAB);
            chk("post_rst_lsb", s_lsb[base], 8'hCD);
            chk("post_rst_sel", s_sel[base], 3);
        end

        // 511-coefficient boundary
        @(negedge clk);
        base = s_msb.size();
        tx = {};
        for (int k = 0; k < 1022; k++) tx.push_back(8'(k));
        do_start(8'd0, 9'd511);
        feed(1022, 1'b0);
        wait_done(60);
        chk("max_coefs_msb", coefs_per_tap_msb, 1);
        chk("max_coefs_lsb", coefs_per_tap_lsb, 8'hFF);
        @(negedge clk);
        chk("max_strobes", s_msb.size() - base, 511);
        if (s_msb.size() >= base + 511) begin
            chk("max_last_msb", s_msb[base+510], 8'hFC);
            chk("max_last_lsb", s_lsb[base+510], 8'hFD);
        end
        chk("max_hold_dropped", fir_hold, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fir_coef_loader.md
# fir_coef_loader

Host-side writer for the FIR equalizer coefficient port. Accepts a band select, coefficient count and a byte stream (MSB then LSB per 16-bit coefficient) from the control/register layer. It sequences the address reset, per-coefficient write strobes and the coefs-per-tap update into the FIR filter bank. It also holds FIR processing off (`fir_hold` drives the filter's `audio_en` low) while coefficient RAMs are rewritten.

## Interface
Parameters:
- `taps_per_filter`, 4: number of filter bands and coefficient RAMs; also the width of `coef_select`.
- `WR_SPACING`, 4: idle cycles after each write strobe. Must be ≥4, because the filter bumps its write address 4 clocks after each strobe.
- `COEFS_RESET`, 255: reset value of the coefs-per-tap output (9 bits).

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle load request. Sampled only in IDLE.
- `band` in 8: target coefficient RAM index, sampled with `start`.
- `coef_count` in 9: number of coefficients to load (1..511), sampled with `start`.
- `abort` in 1: cancels an in-progress load.
- `in_byte` in 8: coefficient byte stream.
- `in_valid` in 1: `in_byte` is valid.
- `in_ready` out 1: loader accepts a byte this cycle.
- `coef_addr_rst` out 1: filter write-address reset pulse.
- `coefficient_wr_en` out 1: filter coefficient write strobe.
- `coef_select` out taps_per_filter: band index presented to the filter.
- `coef_wr_msb_data` out 8: coefficient high byte.
- `coef_wr_lsb_data` out 8: coefficient low byte.
- `coefs_per_tap_lsb` out 8: filter length, bits [7:0].
- `coefs_per_tap_msb` out 1: filter length, bit 8.
- `fir_hold` out 1: high holds the FIR bank in reset (drives `audio_en` low).
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse on successful load completion.
- `error` out 1: one-cycle pulse on rejected start or abort.

## Operation
States: IDLE, ADDR_RST, GET_MSB, GET_LSB, WRITE, SPACE, FINISH.
- **IDLE**
  - On `start` with `coef_count` in 1..511 and `band < taps_per_filter`: latch `band` and `coef_count`, clear the written counter, go to ADDR_RST.
  - Invalid `start` (count 0 or band out of range): pulse `error`, stay in IDLE, leave all outputs unchanged.
- **ADDR_RST**: `coef_addr_rst`=1 for exactly one cycle. `coef_select` and `fir_hold`=1 are driven from this cycle on. Go to GET_MSB.
- **GET_MSB**: `in_ready`=1. On `in_valid`, register `in_byte` into `coef_wr_msb_data` and go to GET_LSB.
- **GET_LSB**: `in_ready`=1. On `in_valid`, register `in_byte` into `coef_wr_lsb_data` and go to WRITE.
- **WRITE**: `coefficient_wr_en`=1 for one cycle with both data bytes and `coef_select` stable. Increment the written counter. Go to SPACE.
- **SPACE**: wait `WR_SPACING` cycles with all outputs held. Then go to FINISH if written == count, else GET_MSB.
- **FINISH**:
  - Load {`coefs_per_tap_msb`, `coefs_per_tap_lsb`} with the latched count.
  - Pulse `done`.
  - Drop `fir_hold` on the next cycle.
  - Return to IDLE.
- **`abort`** in any non-IDLE state:
  - Next state is IDLE, `error` pulses, `fir_hold` drops.
  - `coefs_per_tap` is unchanged; the RAM contents are partial.
  - `abort` has priority over `in_valid` and over state progression.
  - `abort` in IDLE is ignored.
- `start` while busy is ignored. Bytes offered outside GET_MSB/GET_LSB are not accepted (`in_ready`=0).
- `coef_select` and the data byte outputs hold their last values in IDLE.

## Timing
- All outputs are registered except `in_ready`, which is decoded from the state register.
- A byte transfers on a clock edge where `in_valid` && `in_ready`.
- Start-to-`coef_addr_rst`: `coef_addr_rst` is high in the cycle after the `start` edge.
- Minimum strobe-to-strobe interval: `WR_SPACING`+3 cycles (7 at defaults).
- Minimum full load time: 1 + count×(`WR_SPACING`+3) + 1 cycles.
- Reset values:
  - state IDLE;
  - `coef_select`, data bytes, `coefficient_wr_en`, `coef_addr_rst`, `done`, `error`, `busy`, `fir_hold` = 0;
  - {`coefs_per_tap_msb`, `coefs_per_tap_lsb`} = `COEFS_RESET`.
- Reset mid-load returns to IDLE immediately (asynchronous) with the reset values above, with no `done` or `error` pulse.
- `coef_count`=511 (wrap boundary): exactly 511 strobes, final `coefs_per_tap_msb`=1, `coefs_per_tap_lsb`=8'hFF.

## Test plan
- Reset, then idle 10 cycles → `coefs_per_tap` = 9'd255, `fir_hold`=0, `in_ready`=0, no strobes.
- `start`, band=2, count=3, bytes 12 34 56 78 9A BC with `in_valid` held high → 1 `coef_addr_rst`, then 3 strobes at 7-cycle spacing carrying {12,34},{56,78},{9A,BC}, `coef_select`=2, `done` once, `coefs_per_tap`=3.
- Same load with `in_valid` toggling randomly → identical strobe data and order, and strobe spacing ≥7.
- `start` with count=0, and separately with band=4 → `error` pulse, no `coef_addr_rst`, `busy` stays 0.
- `abort` after 2 of 5 coefficients → IDLE next cycle, `error` pulse, `fir_hold` low, `coefs_per_tap` unchanged, no further strobes.
- Assert `reset` in GET_LSB → all outputs return to reset values without waiting for a clock edge; a new `start` afterwards completes normally.
